// File: rtl/store_pkg.sv
// Shared encodings for the store read-modify-write unit: store sizes and FSM states.
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WAIT  = 2'b10,
    WRITE = 2'b11
  } state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational little-endian lane merge: the selected byte/halfword lane takes the
// low bits of data, every other lane keeps the old word.
module byte_lane_merge
  import store_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] old_word,
  input  logic [NB_DATA-1:0] data,
  input  size_t              size,
  input  logic [1:0]         lane,
  output logic [NB_DATA-1:0] merged
);

  logic [NB_DATA-1:0] mask;
  logic [NB_DATA-1:0] ins;
  logic [4:0]         shamt;

  always_comb begin
    mask  = '1;
    ins   = data;
    shamt = '0;
    case (size)
      SIZE_BYTE: begin
        shamt = {lane, 3'b000};
        mask  = {{(NB_DATA-8){1'b0}}, 8'hFF} << shamt;
        ins   = {{(NB_DATA-8){1'b0}}, data[7:0]} << shamt;
      end
      SIZE_HALF: begin
        // Halfword lane is lane[1]; lane[0] is deliberately ignored.
        shamt = {lane[1], 4'b0000};
        mask  = {{(NB_DATA-16){1'b0}}, 16'hFFFF} << shamt;
        ins   = {{(NB_DATA-16){1'b0}}, data[15:0]} << shamt;
      end
      default: begin
        mask = '1;
        ins  = data;
      end
    endcase
    merged = (old_word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Sub-word store engine: SB/SH read the target word, merge, then write; SW writes directly.
// Optional build macro STORE_MISALIGN_CHECK_EN rejects misaligned SH/SW requests.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_size,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_misaligned,
  output logic [NB_ADDR-3:0] o_mem_addr,
  output logic               o_mem_rd_en,
  input  logic [NB_DATA-1:0] i_mem_rd_data,
  input  logic               i_mem_rd_valid,
  output logic               o_mem_wr_en,
  output logic [NB_DATA-1:0] o_mem_wr_data,
  output logic [1:0]         o_state
);

  // Memory handshake: o_mem_rd_en is a single-cycle request; the response is the one
  // cycle where i_mem_rd_valid is high while in WAIT (no backpressure, any other valid
  // is dropped). o_mem_wr_en is a single-cycle fire-and-forget strobe with o_done.

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_DATA-1:0] data_q, rd_word_q, wr_data_q, merged;
  size_t              size_q, size_in;
  logic               wr_en_q, done_q, misaligned, accept;

  assign size_in = (i_size == SIZE_RSVD) ? SIZE_WORD : size_t'(i_size);

`ifdef STORE_MISALIGN_CHECK_EN
  logic mis_q;
  assign misaligned = ((size_in == SIZE_HALF) && i_addr[0]) ||
                      ((size_in == SIZE_WORD) && (i_addr[1:0] != 2'b00));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= (state_q == IDLE) && i_start && misaligned;
  end
  assign o_misaligned = mis_q;
`else
  assign misaligned   = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  assign accept = (state_q == IDLE) && i_start && !misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (size_in == SIZE_WORD) ? WRITE : READ;
      READ:    state_d = WAIT;
      WAIT:    if (i_mem_rd_valid) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  byte_lane_merge #(.NB_DATA(NB_DATA)) u_merge (
    .old_word (rd_word_q),
    .data     (data_q),
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .merged   (merged)
  );

  // Write-side outputs are registered so the strobe is glitch-free and aligned with o_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      size_q    <= SIZE_BYTE;
      rd_word_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= i_addr;
        data_q <= i_data;
        size_q <= size_in;
      end
      if ((state_q == WAIT) && i_mem_rd_valid) rd_word_q <= i_mem_rd_data;
      wr_en_q   <= (state_q == WRITE);
      done_q    <= (state_q == WRITE);
      wr_data_q <= (state_q == WRITE) ? merged : '0;
    end
  end

  assign o_busy        = (state_q != IDLE);
  assign o_mem_rd_en   = (state_q == READ);
  assign o_mem_addr    = addr_q[NB_ADDR-1:2];
  assign o_mem_wr_en   = wr_en_q;
  assign o_done        = done_q;
  assign o_mem_wr_data = wr_data_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit; honours STORE_MISALIGN_CHECK_EN when defined.
module tb_store_rmw_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_data = '0;
  logic [1:0]  i_size = '0;
  logic        o_busy, o_done, o_misaligned, o_mem_rd_en, o_mem_wr_en;
  logic [29:0] o_mem_addr;
  logic [31:0] i_mem_rd_data = '0;
  logic        i_mem_rd_valid = 1'b0;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [logic [29:0]];
  logic [31:0] exp_q[$];

  store_rmw_unit #(.NB_DATA(32), .NB_ADDR(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_start        (i_start),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .i_size         (i_size),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_misaligned   (o_misaligned),
    .o_mem_addr     (o_mem_addr),
    .o_mem_rd_en    (o_mem_rd_en),
    .i_mem_rd_data  (i_mem_rd_data),
    .i_mem_rd_valid (i_mem_rd_valid),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_wr_data  (o_mem_wr_data),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_read(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return 32'h1357_9BDF ^ {w, 2'b00};
  endfunction

  // Reference merge: replace whole bytes of the old word, little-endian.
  function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [7:0] b[4];
    logic [7:0] db[4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      b[i]  = old[8*i +: 8];
      db[i] = d[8*i +: 8];
    end
    case (sz)
      2'b00: b[lo] = db[0];
      2'b01: begin
        b[{lo[1], 1'b0}] = db[0];
        b[{lo[1], 1'b1}] = db[1];
      end
      default: for (int i = 0; i < 4; i++) b[i] = db[i];
    endcase
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int lat, input bit spur, input bit inj, input string name);
    logic [31:0] old, got, exp;
    logic [29:0] wr_addr;
    bit word, wr_done_flag, quiet_bad;
    int exp_k, rd_k, wr_k, rd_cnt;
    word    = (sz[1] == 1'b1);
    old     = mem_read(a[31:2]);
    exp_q.push_back(merge_model(old, d, sz, a[1:0]));
    exp_k   = word ? 2 : 3 + lat;
    rd_k = -1; wr_k = -1; rd_cnt = 0; got = '0; wr_addr = '0; wr_done_flag = 0;
    @(negedge clock);
    i_start = 1'b1; i_addr = a; i_data = d; i_size = sz;
    for (int k = 1; k <= 40 && wr_k < 0; k++) begin
      @(negedge clock);
      i_start = 1'b0;
      i_mem_rd_valid = 1'b0;
      i_mem_rd_data  = $urandom;
      if (inj && k == 2) begin
        i_start = 1'b1; i_addr = ~a; i_data = ~d; i_size = 2'b10;
      end
      if (spur && k == 1) i_mem_rd_valid = 1'b1;
      if (k == 1) begin
        checks++;
        if (o_busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_k1: got %b want 1", name, o_busy);
        end
      end
      if (o_mem_rd_en === 1'b1) begin
        rd_cnt++; rd_k = k;
        checks++;
        if (o_mem_addr !== a[31:2]) begin
          errors++; $display("FAIL %s rd_addr: got %h want %h", name, o_mem_addr, a[31:2]);
        end
      end
      if (rd_k > 0 && k == rd_k + lat) begin
        i_mem_rd_valid = 1'b1; i_mem_rd_data = old;
      end
      if (o_mem_wr_en === 1'b1) begin
        wr_k = k; got = o_mem_wr_data; wr_addr = o_mem_addr; wr_done_flag = o_done;
      end
    end
    i_mem_rd_valid = 1'b0;
    exp = exp_q.pop_front();
    mem[a[31:2]] = exp;
    checks++;
    if (wr_k != exp_k) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, wr_k, exp_k);
    end
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s wr_data: got %h want %h", name, got, exp);
    end
    checks++;
    if (wr_addr !== a[31:2] || wr_done_flag !== 1'b1) begin
      errors++; $display("FAIL %s wr_addr/done: got %h/%b want %h/1", name, wr_addr, wr_done_flag, a[31:2]);
    end
    checks++;
    if (rd_cnt != (word ? 0 : 1)) begin
      errors++; $display("FAIL %s rd_count: got %0d want %0d", name, rd_cnt, word ? 0 : 1);
    end
    quiet_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (o_mem_wr_en !== 1'b0 || o_mem_rd_en !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0)
        quiet_bad = 1;
    end
    checks++;
    if (quiet_bad) begin
      errors++; $display("FAIL %s quiet_after: got activity want none", name);
    end
  endtask

`ifdef STORE_MISALIGN_CHECK_EN
  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
  endfunction

  task automatic do_misaligned(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                               input string name);
    int pulses;
    bit access;
    pulses = 0; access = 0;
    @(negedge clock);
    i_start = 1'b1; i_addr = a; i_data = d; i_size = sz;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      i_start = 1'b0;
      if (o_misaligned === 1'b1) begin
        pulses++;
        checks++;
        if (k != 1) begin
          errors++; $display("FAIL %s mis_cycle: got %0d want 1", name, k);
        end
      end
      if (o_mem_rd_en !== 1'b0 || o_mem_wr_en !== 1'b0 || o_busy !== 1'b0) access = 1;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL %s mis_pulses: got %0d want 1", name, pulses);
    end
    checks++;
    if (access) begin
      errors++; $display("FAIL %s mis_access: got activity want none", name);
    end
  endtask
`endif

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({o_busy, o_done, o_misaligned, o_mem_rd_en, o_mem_wr_en} !== 5'b0 ||
        o_mem_addr !== '0 || o_mem_wr_data !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b mis=%b rd=%b wr=%b addr=%h wd=%h want all 0",
                         o_busy, o_done, o_misaligned, o_mem_rd_en, o_mem_wr_en, o_mem_addr, o_mem_wr_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    do_store(32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1, 0, 0, "sw_0x100");
    mem[30'h40] = 32'h1122_3344;
    do_store(32'h0000_0103, 32'h0000_00AA, 2'b00, 3, 0, 0, "sb_0x103");
    mem[30'h40] = 32'h1122_3344;
    do_store(32'h0000_0102, 32'h0000_BEEF, 2'b01, 2, 0, 0, "sh_0x102");
    mem[30'h40] = 32'h1122_3344;
`ifdef STORE_MISALIGN_CHECK_EN
    do_misaligned(32'h0000_0101, 32'h0000_BEEF, 2'b01, "sh_0x101_mis");
`else
    do_store(32'h0000_0101, 32'h0000_BEEF, 2'b01, 2, 0, 0, "sh_0x101_forced");
`endif
    do_store(32'h0000_0108, 32'hCAFE_F00D, 2'b11, 1, 0, 0, "rsvd_as_sw");
  endtask

  task automatic test_wrap;
    do_store(32'hFFFF_FFFF, 32'h0000_005A, 2'b00, 1, 0, 0, "sb_wrap");
    do_store(32'hFFFF_FFFC, 32'h0BAD_F00D, 2'b10, 1, 0, 0, "sw_wrap");
  endtask

  task automatic test_reset_abort;
    bit bad;
    @(negedge clock);
    i_start = 1'b1; i_addr = 32'h0000_0300; i_data = 32'h0000_0055; i_size = 2'b00;
    @(negedge clock);
    i_start = 1'b0;
    @(negedge clock);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy_pre: got %b want 1", o_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_mem_wr_en !== 1'b0 || o_done !== 1'b0) begin
      errors++; $display("FAIL abort_async: got busy=%b wr=%b done=%b want 0", o_busy, o_mem_wr_en, o_done);
    end
    @(negedge clock);
    reset = 1'b0;
    i_mem_rd_valid = 1'b1; i_mem_rd_data = 32'h7777_7777;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      i_mem_rd_valid = 1'b0;
      if (o_mem_wr_en !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL abort_late_valid: got activity want none");
    end
    do_store(32'h0000_0304, 32'h1234_5678, 2'b10, 1, 0, 0, "sw_after_abort");
  endtask

  task automatic test_start_in_wait;
    mem[30'h50] = 32'hA1B2_C3D4;
    do_store(32'h0000_0141, 32'h0000_0066, 2'b00, 3, 0, 1, "sb_inject");
    do_store(32'h0000_0142, 32'h0000_9988, 2'b01, 1, 1, 1, "sh_inject_spur");
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic [1:0]  sz;
    int lat;
    bit spur, inj;
    for (int n = 0; n < 40; n++) begin
      a    = $urandom_range(0, 63) + (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 : 32'h0);
      d    = $urandom;
      sz   = 2'($urandom_range(0, 3));
      lat  = $urandom_range(1, 4);
      spur = 1'($urandom_range(0, 1));
      inj  = (sz[1] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
      if (is_mis(a, sz)) do_misaligned(a, d, sz, "rand_mis"); else
`endif
      do_store(a, d, sz, lat, spur, inj, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_reset_abort();
    test_start_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 Parameter NB_DATA, default 32: register and memory word width in bits.
REQ-002 Parameter NB_ADDR, default 32: byte-address width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  store request; sampled only in IDLE.
REQ-007 i_addr  in  NB_ADDR  byte address of the store.
REQ-008 i_data  in  NB_DATA  register value; the low byte, low halfword or full word is stored.
REQ-009 i_size  in  2  store size: 00 SB, 01 SH, 10 SW, 11 reserved (treated as SW).
REQ-010 o_busy  out  1  high in every state except IDLE.
REQ-011 o_done  out  1  one-cycle pulse when the memory write is issued.
REQ-012 o_misaligned  out  1  one-cycle pulse on a rejected misaligned request.
REQ-013 o_mem_addr  out  NB_ADDR-2  word address, equal to i_addr[NB_ADDR-1:2] latched at start.
REQ-014 o_mem_rd_en  out  1  one-cycle memory read request.
REQ-015 i_mem_rd_data  in  NB_DATA  memory read word.
REQ-016 i_mem_rd_valid  in  1  read data valid; arbitrary latency of at least 1 cycle.
REQ-017 o_mem_wr_en  out  1  one-cycle memory write strobe.
REQ-018 o_mem_wr_data  out  NB_DATA  merged word to write.

Function
REQ-019 The FSM SHALL have the states IDLE, READ, WAIT, WRITE.
REQ-020 In IDLE with i_start=1, the block SHALL latch addr, data and size; SW goes to WRITE, SB/SH go to READ.
REQ-021 READ SHALL assert o_mem_rd_en for exactly 1 cycle, then go to WAIT.
REQ-022 WAIT SHALL hold until i_mem_rd_valid=1, latch i_mem_rd_data, then go to WRITE.
REQ-023 WRITE SHALL assert o_mem_wr_en and o_done for 1 cycle, then return to IDLE.
REQ-024 Byte lanes are little-endian; the lane is addr[1:0] for SB and addr[1] for SH.
REQ-025 Merge rule: the selected lane takes the low bits of i_data; all other lanes keep the read word unchanged.
REQ-026 SW latency SHALL be 2 cycles from start to o_done; SB/SH latency SHALL be 3 cycles plus the read latency.
REQ-027 i_start SHALL be ignored while o_busy=1, and the latched fields SHALL NOT change.
REQ-028 An i_mem_rd_valid outside WAIT SHALL be ignored.
REQ-029 Wrap-around: word address 0x3FFFFFFF SHALL be handled like any other address, with no carry into other bits.

Reset
REQ-030 Reset SHALL force IDLE and drive all outputs to 0, with latched registers cleared to 0.
REQ-031 Reset during READ/WAIT/WRITE SHALL abort the store: no o_mem_wr_en and no o_done, and a late read response SHALL be ignored.

Configuration
REQ-032 With STORE_MISALIGN_CHECK_EN defined, SH with addr[0]=1 or SW with addr[1:0]!=00 SHALL pulse o_misaligned for 1 cycle, issue no memory access, and stay in IDLE.
REQ-033 Without STORE_MISALIGN_CHECK_EN, the block SHALL tie o_misaligned to 0 and force the low address bits to alignment: SH ignores addr[0], and SW ignores addr[1:0].

Structure
REQ-034 Shared package store_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encodings.
REQ-035 Sub-module byte_lane_merge SHALL be purely combinational, mapping (old word, data, size, lane) to the merged word; the FSM and registers stay in store_rmw_unit.

Verification
REQ-036 SW to addr 0x100 with data 0xDEADBEEF -> no read; write of 0xDEADBEEF to word 0x40; o_done 2 cycles after start.
REQ-037 SB to addr 0x103 with data 0x000000AA, memory word 0x11223344, read latency 3 -> write of 0xAA223344; o_done 6 cycles after start.
REQ-038 SH to addr 0x102 with data 0x0000BEEF, memory word 0x11223344 -> write of 0xBEEF3344.
REQ-039 With STORE_MISALIGN_CHECK_EN, SH to addr 0x101 -> o_misaligned for 1 cycle, no rd_en/wr_en; without it -> write to lanes 0-1.
REQ-040 Reset asserted in WAIT, then rd_valid arrives -> no write and o_busy=0; a following SW completes normally.
REQ-041 i_start pulsed in WAIT with different data -> the first store completes with its original data, and the second request is dropped.
